// File: rtl/comparator_if.sv
// Bus bundle between the MBIST controller and the data comparator:
// compare inputs, magnitude flags and fail-capture results.
interface comparator_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [WIDTH-1:0]      data_t;
  logic [WIDTH-1:0]      ramout;
  logic                  cmp_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  clr;

  logic                  gt;
  logic                  eq;
  logic                  lt;
  logic [WIDTH-1:0]      mismatch;
  logic                  fail;
  logic [CNT_WIDTH-1:0]  fail_count;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [WIDTH-1:0]      first_exp;
  logic [WIDTH-1:0]      first_got;

  modport master (
    output data_t, ramout, cmp_en, addr, clr,
    input  gt, eq, lt, mismatch, fail, fail_count, first_addr, first_exp, first_got
  );

  modport slave (
    input  data_t, ramout, cmp_en, addr, clr,
    output gt, eq, lt, mismatch, fail, fail_count, first_addr, first_exp, first_got
  );
endinterface

// File: rtl/comparator.sv
// MBIST data comparator: combinational unsigned magnitude flags plus a clocked
// capture of the first failing compare and a saturating mismatch count.
module comparator #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         rst,
  comparator_if.slave bus
);

  logic                  gt_w;
  logic                  eq_w;
  logic                  lt_w;
  logic [WIDTH-1:0]      mismatch_w;
  logic                  capture;

  logic                  fail_reg,       fail_next;
  logic [CNT_WIDTH-1:0]  count_reg,      count_next;
  logic [ADDR_WIDTH-1:0] first_addr_reg, first_addr_next;
  logic [WIDTH-1:0]      first_exp_reg,  first_exp_next;
  logic [WIDTH-1:0]      first_got_reg,  first_got_next;

  assign gt_w = (bus.data_t > bus.ramout);
  assign eq_w = (bus.data_t == bus.ramout);
  assign lt_w = (bus.data_t < bus.ramout);

  // Per-bit difference vector shows which data lines disagree.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mismatch
      assign mismatch_w[gi] = bus.data_t[gi] ^ bus.ramout[gi];
    end
  endgenerate

  assign capture = bus.cmp_en && !eq_w;

  always_comb begin
    fail_next       = fail_reg;
    count_next      = count_reg;
    first_addr_next = first_addr_reg;
    first_exp_next  = first_exp_reg;
    first_got_next  = first_got_reg;
    if (bus.clr) begin
      // Clear wins; the compare sampled with it is discarded.
      fail_next       = 1'b0;
      count_next      = '0;
      first_addr_next = '0;
      first_exp_next  = '0;
      first_got_next  = '0;
    end else if (capture) begin
      fail_next = 1'b1;
      if (count_reg != '1) begin
        count_next = count_reg + CNT_WIDTH'(1);
      end
      if (!fail_reg) begin
        first_addr_next = bus.addr;
        first_exp_next  = bus.data_t;
        first_got_next  = bus.ramout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_reg       <= 1'b0;
      count_reg      <= '0;
      first_addr_reg <= '0;
      first_exp_reg  <= '0;
      first_got_reg  <= '0;
    end else begin
      fail_reg       <= fail_next;
      count_reg      <= count_next;
      first_addr_reg <= first_addr_next;
      first_exp_reg  <= first_exp_next;
      first_got_reg  <= first_got_next;
    end
  end

  assign bus.gt         = gt_w;
  assign bus.eq         = eq_w;
  assign bus.lt         = lt_w;
  assign bus.mismatch   = mismatch_w;
  assign bus.fail       = fail_reg;
  assign bus.fail_count = count_reg;
  assign bus.first_addr = first_addr_reg;
  assign bus.first_exp  = first_exp_reg;
  assign bus.first_got  = first_got_reg;

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed flag/capture steps plus a
// randomized run against a simple behavioural model of the capture rules.
module tb_comparator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state for the main instance (16-bit counter).
  bit m_fail;
  int m_cnt;
  int m_addr;
  int m_exp;
  int m_got;

  comparator_if #(.WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) bus ();
  comparator_if #(.WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(2))  bus2 ();

  comparator #(.WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  comparator #(.WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int d, input int r);
    check({tag, " gt"}, {31'd0, bus.gt}, {31'd0, (d > r) ? 1'b1 : 1'b0});
    check({tag, " eq"}, {31'd0, bus.eq}, {31'd0, (d == r) ? 1'b1 : 1'b0});
    check({tag, " lt"}, {31'd0, bus.lt}, {31'd0, (d < r) ? 1'b1 : 1'b0});
    check({tag, " mismatch"}, {24'd0, bus.mismatch}, 32'(d ^ r) & 32'hFF);
  endtask

  task automatic check_capture(input string tag);
    check({tag, " fail"},       {31'd0, bus.fail},       {31'd0, m_fail});
    check({tag, " fail_count"}, {16'd0, bus.fail_count}, 32'(m_cnt));
    check({tag, " first_addr"}, {24'd0, bus.first_addr}, 32'(m_addr));
    check({tag, " first_exp"},  {24'd0, bus.first_exp},  32'(m_exp));
    check({tag, " first_got"},  {24'd0, bus.first_got},  32'(m_got));
  endtask

  function automatic void model_zero();
    m_fail = 1'b0;
    m_cnt  = 0;
    m_addr = 0;
    m_exp  = 0;
    m_got  = 0;
  endfunction

  // Capture rules applied at one rising edge.
  function automatic void model_edge(input bit en, input bit c, input int d, input int r, input int a);
    if (c) begin
      model_zero();
    end else if (en && d != r) begin
      if (!m_fail) begin
        m_addr = a;
        m_exp  = d;
        m_got  = r;
      end
      m_fail = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endfunction

  // Called at posedge+1: drive, take one edge, then compare at posedge+1.
  task automatic cycle(input string tag, input bit en, input bit c, input int d, input int r, input int a);
    bus.cmp_en = en;
    bus.clr    = c;
    bus.data_t = 8'(d);
    bus.ramout = 8'(r);
    bus.addr   = 8'(a);
    @(posedge clk);
    model_edge(en, c, d, r, a);
    #1;
    check_capture(tag);
  endtask

  task automatic comb(input string tag, input int d, input int r);
    bus.cmp_en = 1'b0;
    bus.clr    = 1'b0;
    bus.data_t = 8'(d);
    bus.ramout = 8'(r);
    #5;
    check_flags(tag, d, r);
  endtask

  initial begin
    int d;
    int r;
    int a;
    bit en;
    bit c;

    bus.data_t  = 8'h3C;
    bus.ramout  = 8'h5A;
    bus.cmp_en  = 1'b1;
    bus.addr    = 8'h11;
    bus.clr     = 1'b0;
    bus2.data_t = 8'h00;
    bus2.ramout = 8'h00;
    bus2.cmp_en = 1'b0;
    bus2.addr   = 8'h00;
    bus2.clr    = 1'b0;
    model_zero();

    // Reset holds capture state at zero even with an enabled mismatch present.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_capture("reset");
    check_flags("reset_flags", 'h3C, 'h5A);
    bus.cmp_en = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 254));
      comb("equal", d, d);
    end

    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(1, 254));
      comb("plus1", d, d + 1);
      comb("back_eq", d, d);
      comb("minus1", d, d - 1);
    end

    comb("bound_00_ff", 'h00, 'hFF);
    comb("bound_ff_00", 'hFF, 'h00);
    comb("bound_ff_ff", 'hFF, 'hFF);
    comb("bound_00_00", 'h00, 'h00);

    @(posedge clk);
    #1;
    check_capture("idle_after_comb");

    cycle("miss_a3", 1'b1, 1'b0, 'hA5, 'hA4, 3);
    cycle("miss_a7", 1'b1, 1'b0, 'h12, 'h34, 7);
    check("first_addr_3", {24'd0, bus.first_addr}, 32'd3);
    check("count_2", {16'd0, bus.fail_count}, 32'd2);
    cycle("equal_en", 1'b1, 1'b0, 'h55, 'h55, 9);
    cycle("miss_disabled", 1'b0, 1'b0, 'h01, 'h80, 10);
    cycle("clr_with_miss", 1'b1, 1'b1, 'h0F, 'hF0, 11);
    check("clr_count", {16'd0, bus.fail_count}, 32'd0);
    cycle("after_clr", 1'b1, 1'b0, 'h20, 'h21, 12);

    for (int i = 0; i < 300; i++) begin
      d  = int'($urandom_range(0, 255));
      r  = ($urandom_range(0, 1) == 0) ? d : int'($urandom_range(0, 255));
      a  = int'($urandom_range(0, 255));
      en = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 24) == 0);
      cycle("random", en, c, d, r, a);
      check_flags("random_flags", d, r);
    end

    // Asynchronous reset between edges, with failures recorded.
    cycle("pre_rst", 1'b1, 1'b0, 'h01, 'h02, 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_zero();
    check_capture("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("resume", 1'b1, 1'b0, 'hC3, 'h3C, 42);

    // Narrow counter saturates at 3.
    bus2.data_t = 8'h10;
    bus2.ramout = 8'h01;
    bus2.cmp_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check("sat_count", {30'd0, bus2.fail_count}, 32'((i < 3) ? i : 3));
    end
    check("sat_fail", {31'd0, bus2.fail}, 32'd1);
    bus2.cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator.md
# comparator

Data comparator for the MBIST datapath: compares the expected test pattern (`data_t`) against RAM read data (`ramout`) and drives unsigned magnitude flags (`gt`, `eq`, `lt`) combinationally. A clocked fail-capture section sits on the same inputs. It records a sticky fail flag, a saturating mismatch count, and the address, expected data and read data of the first failing compare. The MBIST controller samples the flags every read cycle and reads the capture registers at end of test.

## Interface
- `WIDTH`, 8, width of `data_t` / `ramout`
- `ADDR_WIDTH`, 8, width of the RAM address tagged onto each compare
- `CNT_WIDTH`, 16, width of the mismatch counter
- `clk`  input  1  single clock; all capture state updates on its rising edge
- `rst`  input  1  asynchronous, active-high reset; clears all capture state immediately
- `data_t`  input  WIDTH  expected test pattern
- `ramout`  input  WIDTH  RAM read data under test
- `cmp_en`  input  1  qualifies the current compare for capture (read strobe)
- `addr`  input  ADDR_WIDTH  RAM address of the current compare
- `clr`  input  1  synchronous clear of capture state
- `gt`  output  1  `data_t > ramout` (unsigned), combinational
- `eq`  output  1  `data_t == ramout`, combinational
- `lt`  output  1  `data_t < ramout` (unsigned), combinational
- `mismatch`  output  WIDTH  `data_t ^ ramout`, combinational
- `fail`  output  1  sticky: at least one enabled compare mismatched
- `fail_count`  output  CNT_WIDTH  number of enabled mismatching compares, saturating
- `first_addr`  output  ADDR_WIDTH  `addr` of first enabled mismatch
- `first_exp`  output  WIDTH  `data_t` of first enabled mismatch
- `first_got`  output  WIDTH  `ramout` of first enabled mismatch

## Operation
- Flags are purely combinational from `data_t`/`ramout`. They are independent of `clk`, `rst`, `cmp_en` and `clr`.
- Exactly one of `gt`, `eq`, `lt` is 1 for any input values, including X-free boundary values 0 and 2^WIDTH-1.
- Comparison is unsigned, with no wrap interpretation. Example: `data_t`=8'hFF, `ramout`=8'h00 gives `gt`=1.
- Capture event: `cmp_en`=1 and `eq`=0 at a rising edge of `clk`. On a capture event:
  - `fail` is set to 1.
  - `fail_count` increments by 1. It holds at all-ones once saturated and never wraps.
  - If `fail` was 0 before the edge, `first_addr`/`first_exp`/`first_got` load `addr`/`data_t`/`ramout`. Otherwise they hold.
- `cmp_en`=0, or an equal compare, leaves all capture state unchanged.
- `clr`=1 at an edge zeroes all capture state, and takes priority over a simultaneous capture event. The compare in that cycle is discarded.
- `rst`=1 asynchronously zeroes all capture state, overriding `clr` and any capture event.

## Timing
- `gt`/`eq`/`lt`/`mismatch`: zero-cycle latency. They are valid within combinational delay of an input change and must settle well under 5 time units in simulation.
- Capture outputs: one-cycle latency. They reflect the compare sampled at the previous rising edge.
- Reset values: `fail`=0, `fail_count`=0, `first_addr`=0, `first_exp`=0, `first_got`=0. Combinational outputs follow their inputs even during reset.
- Reset mid-test clears capture state with no clock required. Capture resumes on the first edge after `rst` deasserts.
- No handshake; `cmp_en` is sampled every edge.

## Test plan
- Random `data_t`, `ramout`=`data_t` -> after 5 time units, `gt`=0 `eq`=1 `lt`=0. Repeat 10 times with random `data_t` in 0..254.
- `ramout`=`data_t`+1 -> `lt`=1. Return `ramout` to `data_t` -> `eq`=1. Then `ramout`=`data_t`-1 -> `gt`=1. Each check at 5 time units, using random `data_t` in 1..254.
- Boundaries: (8'h00,8'hFF) -> `lt`=1; (8'hFF,8'h00) -> `gt`=1; (8'hFF,8'hFF) -> `eq`=1; `mismatch`=8'hFF for the first two.
- With `cmp_en`=1, apply mismatches at `addr` 3 (exp 8'hA5, got 8'hA4) then at `addr` 7 -> `fail`=1, `fail_count`=2, `first_addr`=3, `first_exp`=8'hA5, `first_got`=8'hA4.
- A mismatch with `cmp_en`=0 -> count unchanged. `clr` and a mismatch in the same cycle -> all capture state 0.
- Assert `rst` between clock edges after failures -> capture outputs 0 immediately. With `CNT_WIDTH`=2 and 5 enabled mismatches -> `fail_count`=3.
